// File: rtl/mmu_port_arbiter.sv
// Shares the MMU translation port between IF and D requesters and sequences CP0 MMU commands.
// Define MMU_ARB_PERF_EN to add saturating grant/stall performance counters.

`ifndef MEM_ACCESS
`define MEM_ACCESS   [0:0]
`define MEM_ACCESS_R 1'b0
`define MEM_ACCESS_W 1'b1
`endif

`ifndef MMU_EXCEPTION
`define MMU_EXCEPTION      [2:0]
`define MMU_EXCEPTION_NONE 3'd0
`define MMU_EXCEPTION_TLBL 3'd1
`define MMU_EXCEPTION_TLBS 3'd2
`define MMU_EXCEPTION_MOD  3'd3
`endif

`ifndef MMU_CMD
`define MMU_CMD                  [2:0]
`define MMU_CMD_NONE             3'd0
`define MMU_CMD_READ_REG         3'd1
`define MMU_CMD_WRITE_REG        3'd2
`define MMU_CMD_READ_TLB         3'd3
`define MMU_CMD_WRITE_TLB        3'd4
`define MMU_CMD_WRITE_TLB_RANDOM 3'd5
`define MMU_CMD_PROB_TLB         3'd6
`endif

`ifndef MMU_REG
`define MMU_REG          [2:0]
`define MMU_REG_INDEX    3'd0
`define MMU_REG_RANDOM   3'd1
`define MMU_REG_ENTRYLO0 3'd2
`define MMU_REG_ENTRYLO1 3'd3
`define MMU_REG_CONTEXT  3'd4
`define MMU_REG_PAGEMASK 3'd5
`define MMU_REG_WIRED    3'd6
`define MMU_REG_ENTRYHI  3'd7
`endif

// state | meaning
// IDLE  | nothing in flight; may issue a translation or accept a command
// XLATE | translation issued last cycle; done to owner, may issue again
// CMD   | non-probe command driven to the MMU for one cycle
// PRB0  | PROB_TLB driven for one cycle
// PRB1  | NONE driven while the MMU writes Index
// CDONE | cmd_done pulse with MMU read data
module mmu_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  if_req,
    input  logic [31:0]           if_vaddr,
    output logic                  if_done,
    input  logic                  d_req,
    input  logic [31:0]           d_vaddr,
    input  logic `MEM_ACCESS      d_acc,
    output logic                  d_done,
    output logic [31:0]           xl_paddr,
    output logic `MMU_EXCEPTION   xl_exc,
    input  logic                  cmd_req,
    input  logic `MMU_CMD         cmd_op,
    input  logic `MMU_REG         cmd_reg,
    input  logic [31:0]           cmd_wdata,
    output logic                  cmd_done,
    output logic [31:0]           cmd_rdata,
    output logic                  mmu_addrValid,
    output logic [31:0]           mmu_vAddr,
    output logic `MEM_ACCESS      mmu_acc,
    output logic `MMU_CMD         mmu_cmd_o,
    output logic `MMU_REG         mmu_reg_o,
    output logic [31:0]           mmu_wdata,
    input  logic [31:0]           mmu_pAddr,
    input  logic `MMU_EXCEPTION   mmu_exc,
    input  logic [31:0]           mmu_rdata
`ifdef MMU_ARB_PERF_EN
    ,
    output logic [31:0]           perf_if_grants,
    output logic [31:0]           perf_d_grants,
    output logic [31:0]           perf_stall_cycles
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_XLATE, S_CMD, S_PRB0, S_PRB1, S_CDONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    owner_t     owner;
    logic [3:0] starve_cnt;
    logic       grant_if;
    logic       grant_d;
    logic       issue;

    // A pending command blocks new translations so commands cannot be starved.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (!res && !cmd_req && (state == S_IDLE || state == S_XLATE)) begin
            if (if_req && (!d_req || starve_cnt == LIMIT)) grant_if = 1'b1;
            else if (d_req)                                 grant_d  = 1'b1;
        end
        issue = grant_if | grant_d;
    end

    assign mmu_addrValid = issue;
    assign mmu_vAddr     = grant_if ? if_vaddr : (grant_d ? d_vaddr : 32'h0);
    assign mmu_acc       = grant_d ? d_acc : `MEM_ACCESS_R;

    assign if_done  = (state == S_XLATE) && (owner == OWN_IF);
    assign d_done   = (state == S_XLATE) && (owner == OWN_D);
    assign xl_paddr = mmu_pAddr;
    assign xl_exc   = mmu_exc;

    assign mmu_cmd_o = (state == S_CMD)  ? cmd_op :
                       (state == S_PRB0) ? `MMU_CMD_PROB_TLB : `MMU_CMD_NONE;
    assign mmu_reg_o = (state == S_CMD) ? cmd_reg : '0;
    assign mmu_wdata = (state == S_CMD) ? cmd_wdata : 32'h0;
    assign cmd_done  = (state == S_CDONE);
    assign cmd_rdata = cmd_done ? mmu_rdata : 32'h0;

    always_ff @(posedge clk) begin
        if (res) begin
            state      <= S_IDLE;
            owner      <= OWN_NONE;
            starve_cnt <= '0;
        end else begin
            if (!if_req || grant_if)
                starve_cnt <= '0;
            else if (grant_d && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 4'd1;

            case (state)
                S_IDLE, S_XLATE: begin
                    if (cmd_req) begin
                        state <= (cmd_op == `MMU_CMD_PROB_TLB) ? S_PRB0 : S_CMD;
                        owner <= OWN_NONE;
                    end else if (issue) begin
                        state <= S_XLATE;
                        owner <= grant_if ? OWN_IF : OWN_D;
                    end else begin
                        state <= S_IDLE;
                        owner <= OWN_NONE;
                    end
                end
                S_CMD:   state <= S_CDONE;
                S_PRB0:  state <= S_PRB1;
                S_PRB1:  state <= S_CDONE;
                S_CDONE: state <= S_IDLE;
                default: begin
                    state <= S_IDLE;
                    owner <= OWN_NONE;
                end
            endcase
        end
    end

`ifdef MMU_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (res) begin
            perf_if_grants    <= '0;
            perf_d_grants     <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (grant_if && perf_if_grants != 32'hffff_ffff)
                perf_if_grants <= perf_if_grants + 32'd1;
            if (grant_d && perf_d_grants != 32'hffff_ffff)
                perf_d_grants <= perf_d_grants + 32'd1;
            if ((if_req || d_req) && !issue && perf_stall_cycles != 32'hffff_ffff)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mmu_port_arbiter.sv
// Bench for mmu_port_arbiter: small MMU stand-in, queue-based reference model, directed scenarios.

`ifndef MEM_ACCESS
`define MEM_ACCESS   [0:0]
`define MEM_ACCESS_R 1'b0
`define MEM_ACCESS_W 1'b1
`endif

`ifndef MMU_EXCEPTION
`define MMU_EXCEPTION      [2:0]
`define MMU_EXCEPTION_NONE 3'd0
`define MMU_EXCEPTION_TLBL 3'd1
`define MMU_EXCEPTION_TLBS 3'd2
`define MMU_EXCEPTION_MOD  3'd3
`endif

`ifndef MMU_CMD
`define MMU_CMD                  [2:0]
`define MMU_CMD_NONE             3'd0
`define MMU_CMD_READ_REG         3'd1
`define MMU_CMD_WRITE_REG        3'd2
`define MMU_CMD_READ_TLB         3'd3
`define MMU_CMD_WRITE_TLB        3'd4
`define MMU_CMD_WRITE_TLB_RANDOM 3'd5
`define MMU_CMD_PROB_TLB         3'd6
`endif

`ifndef MMU_REG
`define MMU_REG          [2:0]
`define MMU_REG_INDEX    3'd0
`define MMU_REG_RANDOM   3'd1
`define MMU_REG_ENTRYLO0 3'd2
`define MMU_REG_ENTRYLO1 3'd3
`define MMU_REG_CONTEXT  3'd4
`define MMU_REG_PAGEMASK 3'd5
`define MMU_REG_WIRED    3'd6
`define MMU_REG_ENTRYHI  3'd7
`endif

module tb_mmu_port_arbiter;

    localparam int LIMIT = 4;

    logic                clk = 1'b0;
    logic                res;
    logic                if_req, d_req, cmd_req;
    logic [31:0]         if_vaddr, d_vaddr, cmd_wdata;
    logic `MEM_ACCESS    d_acc;
    logic `MMU_CMD       cmd_op;
    logic `MMU_REG       cmd_reg;
    logic                if_done, d_done, cmd_done, mmu_addrValid;
    logic [31:0]         xl_paddr, cmd_rdata, mmu_vAddr, mmu_wdata;
    logic `MMU_EXCEPTION xl_exc;
    logic `MEM_ACCESS    mmu_acc;
    logic `MMU_CMD       mmu_cmd_o;
    logic `MMU_REG       mmu_reg_o;
    logic [31:0]         mmu_pAddr, mmu_rdata;
    logic `MMU_EXCEPTION mmu_exc;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    mmu_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .res(res),
        .if_req(if_req), .if_vaddr(if_vaddr), .if_done(if_done),
        .d_req(d_req), .d_vaddr(d_vaddr), .d_acc(d_acc), .d_done(d_done),
        .xl_paddr(xl_paddr), .xl_exc(xl_exc),
        .cmd_req(cmd_req), .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
        .cmd_done(cmd_done), .cmd_rdata(cmd_rdata),
        .mmu_addrValid(mmu_addrValid), .mmu_vAddr(mmu_vAddr), .mmu_acc(mmu_acc),
        .mmu_cmd_o(mmu_cmd_o), .mmu_reg_o(mmu_reg_o), .mmu_wdata(mmu_wdata),
        .mmu_pAddr(mmu_pAddr), .mmu_exc(mmu_exc), .mmu_rdata(mmu_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // MMU stand-in: kseg0 is direct-mapped, other pages go through an 8-entry TLB
    logic [31:0] mregs [8];
    logic [19:0] tvpn  [8];
    logic        tval  [8];
    logic [31:0] lv;
    logic        la;
    logic        prb_pend;
    logic [31:0] prb_res;
    logic [31:0] hit;

    function automatic logic [31:0] tlb_find(input logic [19:0] vpn);
        tlb_find = 32'h8000_0000;
        for (int i = 0; i < 8; i++)
            if (tval[i] && tvpn[i] == vpn) tlb_find = 32'(i);
    endfunction

    always @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < 8; i++) begin
                mregs[i] <= 32'h0;
                tvpn[i]  <= 20'h0;
                tval[i]  <= 1'b0;
            end
            lv <= 32'h0; la <= 1'b0; mmu_rdata <= 32'h0;
            prb_pend <= 1'b0; prb_res <= 32'h0;
        end else begin
            if (mmu_addrValid) begin
                lv <= mmu_vAddr;
                la <= mmu_acc;
            end
            prb_pend <= 1'b0;
            if (prb_pend) mregs[0] <= prb_res;
            case (mmu_cmd_o)
                `MMU_CMD_WRITE_REG: mregs[mmu_reg_o] <= mmu_wdata;
                `MMU_CMD_READ_REG:  mmu_rdata <= mregs[mmu_reg_o];
                `MMU_CMD_WRITE_TLB: begin
                    tvpn[mregs[0][2:0]] <= mregs[7][31:12];
                    tval[mregs[0][2:0]] <= 1'b1;
                end
                `MMU_CMD_PROB_TLB: begin
                    prb_pend <= 1'b1;
                    prb_res  <= tlb_find(mregs[7][31:12]);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        hit       = tlb_find(lv[31:12]);
        mmu_pAddr = 32'h0;
        mmu_exc   = `MMU_EXCEPTION_NONE;
        if (lv[31:29] == 3'b100)
            mmu_pAddr = {3'b000, lv[28:0]};
        else if (!hit[31])
            mmu_pAddr = {20'h00100 + {17'h0, hit[2:0]}, lv[11:0]};
        else
            mmu_exc = la ? `MMU_EXCEPTION_TLBS : `MMU_EXCEPTION_TLBL;
    end

    // Per-cycle trace used by the literal checks
    bit          tr_av  [4096];
    bit          tr_ifd [4096];
    bit          tr_dd  [4096];
    bit          tr_cd  [4096];
    logic [2:0]  tr_cmd [4096];
    logic [31:0] tr_va  [4096];
    logic [31:0] tr_rd  [4096];

    // Reference model: a done follows each grant by one cycle; an accepted command
    // becomes a fixed script of MMU command values ending in a done cycle.
    int m_last   = 0;  // 0 none, 1 IF, 2 D granted in the previous cycle
    int m_streak = 0;
    int q_cmd[$];
    bit q_cd[$];

    initial begin
        forever begin
            int win;
            int e_cmd;
            bit e_cd;
            bit busy;
            @(negedge clk);
            tr_av[cyc] = mmu_addrValid; tr_ifd[cyc] = if_done; tr_dd[cyc] = d_done;
            tr_cd[cyc] = cmd_done; tr_cmd[cyc] = mmu_cmd_o; tr_va[cyc] = mmu_vAddr;
            tr_rd[cyc] = cmd_rdata;

            busy  = (q_cmd.size() != 0);
            e_cmd = busy ? q_cmd[0] : 0;
            e_cd  = busy ? q_cd[0] : 1'b0;
            win   = 0;
            if (!res && !busy && !cmd_req) begin
                if (if_req && d_req) win = (m_streak >= LIMIT) ? 1 : 2;
                else if (if_req)     win = 1;
                else if (d_req)      win = 2;
            end

            check("addr_valid", 32'(mmu_addrValid), 32'(win != 0));
            if (win != 0) begin
                check("vaddr", mmu_vAddr, (win == 1) ? if_vaddr : d_vaddr);
                check("acc", 32'(mmu_acc), (win == 1) ? 32'(`MEM_ACCESS_R) : 32'(d_acc));
            end
            check("if_done", 32'(if_done), 32'(m_last == 1));
            check("d_done", 32'(d_done), 32'(m_last == 2));
            check("xl_paddr", xl_paddr, mmu_pAddr);
            check("xl_exc", 32'(xl_exc), 32'(mmu_exc));
            check("mmu_cmd", 32'(mmu_cmd_o), 32'(e_cmd));
            if (e_cmd == `MMU_CMD_READ_REG || e_cmd == `MMU_CMD_WRITE_REG) begin
                check("mmu_reg", 32'(mmu_reg_o), 32'(cmd_reg));
                check("mmu_wdata", mmu_wdata, cmd_wdata);
            end
            check("cmd_done", 32'(cmd_done), 32'(e_cd));
            check("cmd_rdata", cmd_rdata, e_cd ? mmu_rdata : 32'h0);

            if (res) begin
                m_last = 0; m_streak = 0;
                q_cmd.delete(); q_cd.delete();
            end else begin
                if (!if_req) m_streak = 0;
                if (busy) begin
                    void'(q_cmd.pop_front());
                    void'(q_cd.pop_front());
                    m_last = 0;
                end else if (cmd_req) begin
                    m_last = 0;
                    if (cmd_op == `MMU_CMD_PROB_TLB) begin
                        q_cmd.push_back(32'(`MMU_CMD_PROB_TLB)); q_cd.push_back(1'b0);
                        q_cmd.push_back(0); q_cd.push_back(1'b0);
                    end else begin
                        q_cmd.push_back(32'(cmd_op)); q_cd.push_back(1'b0);
                    end
                    q_cmd.push_back(0); q_cd.push_back(1'b1);
                end else begin
                    m_last = win;
                    if (win == 1) m_streak = 0;
                    else if (win == 2 && if_req && m_streak < LIMIT) m_streak++;
                end
            end
        end
    end

    task automatic do_cmd(input logic [2:0] op, input logic [2:0] rg, input logic [31:0] wd,
                          output logic [31:0] rd);
        bit got = 1'b0;
        @(posedge clk); #1;
        cmd_req = 1'b1; cmd_op = op; cmd_reg = rg; cmd_wdata = wd;
        rd = 32'h0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (cmd_done) begin
                got = 1'b1;
                rd  = cmd_rdata;
            end
        end
        check("cmd_handshake", 32'(got), 32'd1);
        @(posedge clk); #1;
        cmd_req = 1'b0;
    endtask

    task automatic do_xl(input int who, input logic [31:0] va, input logic acc,
                         output logic [31:0] pa, output logic [2:0] ex,
                         output int t_iss, output int t_done);
        bit got = 1'b0;
        @(posedge clk); #1;
        t_iss = cyc; t_done = -1; pa = 32'h0; ex = 3'd7;
        if (who == 1) begin if_vaddr = va; if_req = 1'b1; end
        else begin d_vaddr = va; d_acc = acc; d_req = 1'b1; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((who == 1) ? if_done : d_done) begin
                got = 1'b1; pa = xl_paddr; ex = xl_exc; t_done = cyc;
            end
        end
        check("xl_handshake", 32'(got), 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pa, rd;
        logic [2:0]  ex;
        int          ti, td, t0;

        res = 1'b1; if_req = 1'b1; d_req = 1'b1; cmd_req = 1'b0;
        if_vaddr = 32'h8000_0100; d_vaddr = 32'h8000_0200; d_acc = `MEM_ACCESS_R;
        cmd_op = `MMU_CMD_NONE; cmd_reg = '0; cmd_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_addr_valid", 32'(mmu_addrValid), 32'd0);
        check("rst_cmd", 32'(mmu_cmd_o), 32'(`MMU_CMD_NONE));
        check("rst_done", 32'({if_done, d_done, cmd_done}), 32'd0);
        check("rst_rdata", cmd_rdata, 32'h0);
        @(posedge clk); #1;
        res = 1'b0; if_req = 1'b0; d_req = 1'b0;

        // IF alone through kseg0
        do_xl(1, 32'h8000_1000, `MEM_ACCESS_R, pa, ex, ti, td);
        check("if_issue_cycle", 32'(tr_av[ti]), 32'd1);
        check("if_latency", 32'(td - ti), 32'd1);
        check("if_paddr", pa, 32'h0000_1000);
        check("if_exc", 32'(ex), 32'(`MMU_EXCEPTION_NONE));

        // D to unmapped page: store and load miss
        do_xl(2, 32'h0040_0000, `MEM_ACCESS_W, pa, ex, ti, td);
        check("d_store_exc", 32'(ex), 32'(`MMU_EXCEPTION_TLBS));
        do_xl(2, 32'h0040_0000, `MEM_ACCESS_R, pa, ex, ti, td);
        check("d_load_exc", 32'(ex), 32'(`MMU_EXCEPTION_TLBL));

        // IF and D held together: D,D,D,D,IF repeating with one done per cycle
        @(posedge clk); #1;
        t0 = cyc;
        if_vaddr = 32'h8000_2000; d_vaddr = 32'h8000_3000; d_acc = `MEM_ACCESS_R;
        if_req = 1'b1; d_req = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        if_req = 1'b0; d_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("starve_grant", tr_va[t0 + i], (i % 5 == 4) ? 32'h8000_2000 : 32'h8000_3000);
            check("one_done", 32'(int'(tr_ifd[t0 + i + 1]) + int'(tr_dd[t0 + i + 1])), 32'd1);
        end

        // READ_REG EntryHi raised while D is in its done cycle
        do_cmd(`MMU_CMD_WRITE_REG, `MMU_REG_ENTRYHI, 32'h1234_5000, rd);
        @(posedge clk); #1;
        t0 = cyc; d_req = 1'b1; d_vaddr = 32'h8000_4000; d_acc = `MEM_ACCESS_R;
        @(posedge clk); #1;
        cmd_req = 1'b1; cmd_op = `MMU_CMD_READ_REG; cmd_reg = `MMU_REG_ENTRYHI;
        @(posedge clk); #1;
        d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cmd_req = 1'b0;
        check("rr_d_issue", 32'(tr_av[t0]), 32'd1);
        check("rr_d_done", 32'(tr_dd[t0 + 1]), 32'd1);
        check("rr_cmd_cycle", 32'(tr_cmd[t0 + 2]), 32'(`MMU_CMD_READ_REG));
        check("rr_no_early_done", 32'(tr_cd[t0 + 2]), 32'd0);
        check("rr_cmd_done", 32'(tr_cd[t0 + 3]), 32'd1);
        check("rr_rdata", tr_rd[t0 + 3], 32'h1234_5000);

        // Map entry 5, clear Index, probe with IF waiting
        do_cmd(`MMU_CMD_WRITE_REG, `MMU_REG_INDEX, 32'd5, rd);
        do_cmd(`MMU_CMD_WRITE_TLB, `MMU_REG_INDEX, 32'd0, rd);
        do_cmd(`MMU_CMD_WRITE_REG, `MMU_REG_INDEX, 32'd0, rd);
        @(posedge clk); #1;
        t0 = cyc; if_req = 1'b1; if_vaddr = 32'h8000_5000;
        cmd_req = 1'b1; cmd_op = `MMU_CMD_PROB_TLB; cmd_reg = `MMU_REG_INDEX;
        repeat (4) @(posedge clk);
        #1;
        cmd_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if_req = 1'b0;
        check("prb_cmd0", 32'(tr_cmd[t0 + 1]), 32'(`MMU_CMD_PROB_TLB));
        check("prb_cmd1", 32'(tr_cmd[t0 + 2]), 32'(`MMU_CMD_NONE));
        check("prb_done", 32'(tr_cd[t0 + 3]), 32'd1);
        for (int i = 0; i < 4; i++) check("prb_no_xlate", 32'(tr_av[t0 + i]), 32'd0);
        check("prb_if_after", 32'(tr_av[t0 + 4]), 32'd1);
        do_cmd(`MMU_CMD_READ_REG, `MMU_REG_INDEX, 32'd0, rd);
        check("prb_index", rd, 32'd5);
        do_xl(1, 32'h1234_5abc, `MEM_ACCESS_R, pa, ex, ti, td);
        check("mapped_paddr", pa, 32'h0010_5abc);

        // Two D grants build the streak, then reset lands in PRB0
        @(posedge clk); #1;
        t0 = cyc;
        if_vaddr = 32'h8000_6000; d_vaddr = 32'h8000_7000; d_acc = `MEM_ACCESS_R;
        if_req = 1'b1; d_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cmd_req = 1'b1; cmd_op = `MMU_CMD_PROB_TLB;
        @(posedge clk); #1;
        res = 1'b1; cmd_req = 1'b0;
        @(posedge clk); #1;
        res = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        if_req = 1'b0; d_req = 1'b0;
        check("rstp_prb0", 32'(tr_cmd[t0 + 3]), 32'(`MMU_CMD_PROB_TLB));
        check("rstp_no_issue", 32'(tr_av[t0 + 3]), 32'd0);
        check("rstp_cmd_none", 32'(tr_cmd[t0 + 4]), 32'(`MMU_CMD_NONE));
        for (int i = 4; i < 7; i++) check("rstp_no_done", 32'(tr_cd[t0 + i]), 32'd0);
        check("rstp_streak_d", tr_va[t0 + 6], 32'h8000_7000);
        check("rstp_streak_if", tr_va[t0 + 8], 32'h8000_6000);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
